// File: rtl/equiv_checker_pkg.sv
// Shared types and constants for the exhaustive equivalence checker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package equiv_checker_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } equiv_state_t;

  localparam int MAX_PIPELINE_DEPTH = 15;
  // Width of the drain counter; it counts 0..MAX_PIPELINE_DEPTH-1.
  localparam int DRAIN_CNT_W = $clog2(MAX_PIPELINE_DEPTH + 1);

endpackage

// File: rtl/equiv_checker_delay_line.sv
// Shift register carrying {valid, stim} alongside the DUT pipelines.
// Latency: DEPTH cycles; DEPTH=0 is a combinational pass-through.
// Backpressure: none; shifts every cycle, synchronous clear via rst_i or clr_i.
//
// Ports:
//   clk_i, rst_i  clock and synchronous active-high reset
//   clr_i         synchronous clear (asserted when a run starts)
//   vld_i/stim_i  tag entering the line (this cycle's stimulus)
//   vld_o/stim_o  tag leaving the line, DEPTH cycles later
module equiv_delay_line #(
  parameter int W     = 2,
  parameter int DEPTH = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         vld_i,
  input  logic [W-1:0] stim_i,
  output logic         vld_o,
  output logic [W-1:0] stim_o
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign vld_o  = vld_i;
      assign stim_o = stim_i;
      // Clock and clears have no state to act on in this configuration.
      logic unused_ctrl;
      assign unused_ctrl = ^{clk_i, rst_i, clr_i};
    end else begin : g_shift
      logic [W:0] stage_q [DEPTH];

      always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
          for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else begin
          stage_q[0] <= {vld_i, stim_i};
          for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
      end

      assign {vld_o, stim_o} = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/equiv_checker.sv
// Exhaustive in-fabric equivalence checker for a test/ground-truth DUT pair.
// Latency: run takes 2^IN_WIDTH + PIPELINE_DEPTH busy cycles; done follows.
// Backpressure: none; start is ignored while busy.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start                    request a run (accepted in IDLE or DONE)
//   stim_out                 registered stimulus to both DUTs
//   test_out, truth_out      DUT outputs, PIPELINE_DEPTH cycles after stim_out
//   busy, done, pass         run status (registered)
//   mismatch_count           number of mismatching vectors
//   first_fail_valid/_stim   first mismatching vector capture
// Optional feature: define EQUIV_CHECKER_STOP_ON_FAIL_EN to end the run on
// the first mismatch (count stays at 1, stim_out freezes).
module equiv_checker
  import equiv_checker_pkg::*;
#(
  parameter int IN_WIDTH       = 2,
  parameter int OUT_WIDTH      = 1,
  parameter int PIPELINE_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic [IN_WIDTH-1:0] stim_out,
  input  logic [OUT_WIDTH-1:0] test_out,
  input  logic [OUT_WIDTH-1:0] truth_out,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [IN_WIDTH:0]   mismatch_count,
  output logic                first_fail_valid,
  output logic [IN_WIDTH-1:0] first_fail_stim
);

  localparam int CW       = IN_WIDTH + 1;
  localparam int DEPTH_M1 = (PIPELINE_DEPTH > 0) ? PIPELINE_DEPTH - 1 : 0;

  equiv_state_t             state_q, state_d;
  logic [IN_WIDTH-1:0]      stim_q, stim_d;
  logic [DRAIN_CNT_W-1:0]   drain_q, drain_d;
  logic [CW-1:0]            mcount_q, mcount_d;
  logic                     ffv_q, ffv_d;
  logic [IN_WIDTH-1:0]      ffs_q, ffs_d;
  logic                     busy_q, done_q, pass_q;

  logic                     enter_run;
  logic                     dl_vld;
  logic [IN_WIDTH-1:0]      dl_stim;
  logic                     cmp_hit;

  // Tags each presented vector so its DUT response is recognised on arrival.
  equiv_delay_line #(
    .W     (IN_WIDTH),
    .DEPTH (PIPELINE_DEPTH)
  ) u_delay (
    .clk_i  (clk),
    .rst_i  (rst),
    .clr_i  (enter_run),
    .vld_i  (state_q == RUN),
    .stim_i (stim_q),
    .vld_o  (dl_vld),
    .stim_o (dl_stim)
  );

  // Only compare while a run is live; after an early stop, leftover tags in
  // the delay line must not be counted.
  assign cmp_hit = dl_vld && ((state_q == RUN) || (state_q == DRAIN)) &&
                   (test_out != truth_out);

  always_comb begin
    state_d   = state_q;
    stim_d    = stim_q;
    drain_d   = drain_q;
    mcount_d  = mcount_q;
    ffv_d     = ffv_q;
    ffs_d     = ffs_q;
    enter_run = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = RUN;
          stim_d    = '0;
          mcount_d  = '0;
          ffv_d     = 1'b0;
          ffs_d     = '0;
          enter_run = 1'b1;
        end
      end
      RUN: begin
        if (stim_q == '1) begin
          if (PIPELINE_DEPTH == 0) begin
            state_d = DONE;
          end else begin
            state_d = DRAIN;
            drain_d = '0;
          end
        end else begin
          stim_d = stim_q + IN_WIDTH'(1);
        end
      end
      DRAIN: begin
        if (drain_q == DRAIN_CNT_W'(DEPTH_M1)) state_d = DONE;
        else                                   drain_d = drain_q + DRAIN_CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase

    if (cmp_hit) begin
      mcount_d = mcount_q + CW'(1);
      if (!ffv_q) begin
        ffv_d = 1'b1;
        ffs_d = dl_stim;
      end
`ifdef EQUIV_CHECKER_STOP_ON_FAIL_EN
      state_d = DONE;
      stim_d  = stim_q;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      stim_q   <= '0;
      drain_q  <= '0;
      mcount_q <= '0;
      ffv_q    <= 1'b0;
      ffs_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      stim_q   <= stim_d;
      drain_q  <= drain_d;
      mcount_q <= mcount_d;
      ffv_q    <= ffv_d;
      ffs_q    <= ffs_d;
      // Status flags are decoded from next state so they change with it.
      busy_q   <= (state_d == RUN) || (state_d == DRAIN);
      done_q   <= (state_d == DONE);
      pass_q   <= (state_d == DONE) && (mcount_d == '0);
    end
  end

  assign stim_out         = stim_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign mismatch_count   = mcount_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_stim  = ffs_q;

endmodule

// File: tb/tb_equiv_checker.sv
// Directed bench for equiv_checker: checker A drives 2-stage AND/OR DUT
// models (depth 2), checker B drives combinational XOR/XNOR (depth 0).
// Expected values are hand-derived; stop-on-fail build has its own set.
module tb_equiv_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start_a, start_b, sel_or;
  logic [1:0] stim_a, stim_b, ffs_a, ffs_b;
  logic       test_a, truth_a, test_b, truth_b;
  logic       busy_a, done_a, pass_a, ffv_a;
  logic       busy_b, done_b, pass_b, ffv_b;
  logic [2:0] cnt_a, cnt_b;

  equiv_checker #(.IN_WIDTH(2), .OUT_WIDTH(1), .PIPELINE_DEPTH(2)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .stim_out(stim_a),
    .test_out(test_a), .truth_out(truth_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .mismatch_count(cnt_a), .first_fail_valid(ffv_a),
    .first_fail_stim(ffs_a)
  );

  equiv_checker #(.IN_WIDTH(2), .OUT_WIDTH(1), .PIPELINE_DEPTH(0)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .stim_out(stim_b),
    .test_out(test_b), .truth_out(truth_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .mismatch_count(cnt_b), .first_fail_valid(ffv_b),
    .first_fail_stim(ffs_b)
  );

  // Two-stage DUT models: test is a&b (or a|b when sel_or), truth is ~(~a|~b).
  logic t1 = 1'b0, t2 = 1'b0, g1 = 1'b0, g2 = 1'b0;
  always @(posedge clk) begin
    t1 <= sel_or ? (stim_a[1] | stim_a[0]) : (stim_a[1] & stim_a[0]);
    g1 <= ~(~stim_a[1] | ~stim_a[0]);
    t2 <= t1;
    g2 <= g1;
  end
  assign test_a  = t2;
  assign truth_a = g2;
  assign test_b  = stim_b[1] ^ stim_b[0];
  assign truth_b = ~(stim_b[1] ^ stim_b[0]);

  int n_checks = 0;
  int n_err    = 0;

  // Results of the last run
  int         r_done, r_busy_cnt, r_first_busy, r_overlap;
  logic [2:0] r_cnt;
  logic [1:0] r_ffs;
  logic       r_ffv, r_pass, r_done_end;
  logic [1:0] r_stim [0:15];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at posedge+1 (this is cycle 0). Start is raised in cycle 0, then
  // 20 cycles are observed at the negedge. Optional start pulse / reset at a
  // given cycle number.
  task automatic run(input bit use_b, input int pulse_cyc, input int rst_cyc);
    logic bz, dn;
    logic [1:0] st;
    r_done = -1; r_busy_cnt = 0; r_first_busy = -1; r_overlap = 0;
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 20; c++) begin
      start_a = (!use_b && c == pulse_cyc);
      start_b = ( use_b && c == pulse_cyc);
      rst     = (c == rst_cyc);
      @(negedge clk);
      bz = use_b ? busy_b : busy_a;
      dn = use_b ? done_b : done_a;
      st = use_b ? stim_b : stim_a;
      if (c < 16) r_stim[c] = st;
      if (bz) begin
        r_busy_cnt++;
        if (r_first_busy < 0) r_first_busy = c;
      end
      if (bz && dn) r_overlap++;
      if (dn && r_done < 0) r_done = c;
      @(posedge clk); #1;
    end
    start_a = 1'b0; start_b = 1'b0; rst = 1'b0;
    r_cnt      = use_b ? cnt_b  : cnt_a;
    r_ffs      = use_b ? ffs_b  : ffs_a;
    r_ffv      = use_b ? ffv_b  : ffv_a;
    r_pass     = use_b ? pass_b : pass_a;
    r_done_end = use_b ? done_b : done_a;
  endtask

  task automatic check_or_run(input string tag);
`ifdef EQUIV_CHECKER_STOP_ON_FAIL_EN
    check({tag, "_done_cyc"}, r_done, 5);
    check({tag, "_count"}, r_cnt, 1);
    check({tag, "_busy_cycles"}, r_busy_cnt, 4);
`else
    check({tag, "_done_cyc"}, r_done, 7);
    check({tag, "_count"}, r_cnt, 2);
    check({tag, "_busy_cycles"}, r_busy_cnt, 6);
`endif
    check({tag, "_ffs"}, r_ffs, 1);
    check({tag, "_ffv"}, r_ffv, 1);
    check({tag, "_pass"}, r_pass, 0);
    check({tag, "_done_held"}, r_done_end, 1);
    check({tag, "_overlap"}, r_overlap, 0);
  endtask

  initial begin
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; sel_or = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_stim", stim_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_pass", pass_a, 0);
    check("rst_count", cnt_a, 0);
    check("rst_ffv", ffv_a, 0);
    check("rst_ffs", ffs_a, 0);
    check("rst_b_done", done_b, 0);
    @(posedge clk); #1;

    // Matching AND pair
    run(0, -1, -1);
    check("and_done_cyc", r_done, 7);
    check("and_pass", r_pass, 1);
    check("and_count", r_cnt, 0);
    check("and_ffv", r_ffv, 0);
    check("and_stim1", r_stim[1], 0);
    check("and_stim2", r_stim[2], 1);
    check("and_stim3", r_stim[3], 2);
    check("and_stim4", r_stim[4], 3);
    check("and_drain_hold", r_stim[6], 3);
    check("and_first_busy", r_first_busy, 1);
    check("and_busy_cycles", r_busy_cnt, 6);
    check("and_overlap", r_overlap, 0);
    check("and_done_held", r_done_end, 1);

    // OR test DUT, started from DONE
    sel_or = 1'b1;
    run(0, -1, -1);
    check_or_run("or");

    // start pulse mid-run is ignored
    run(0, 3, -1);
    check_or_run("or_midstart");

    // restart from DONE gives identical results
    run(0, -1, -1);
    check_or_run("or_rerun");

    // reset in cycle 3 discards the run
    run(0, -1, 3);
    check("rst_mid_done_cyc", r_done, -1);
    check("rst_mid_count", r_cnt, 0);
    check("rst_mid_ffv", r_ffv, 0);
    check("rst_mid_busy_cycles", r_busy_cnt, 3);
    check("rst_mid_stim", r_stim[10], 0);

    // restart with matching DUTs
    sel_or = 1'b0;
    run(0, -1, -1);
    check("after_rst_done_cyc", r_done, 7);
    check("after_rst_count", r_cnt, 0);
    check("after_rst_pass", r_pass, 1);
    check("after_rst_ffv", r_ffv, 0);

    // Depth 0, XOR vs XNOR: every vector mismatches
    run(1, -1, -1);
`ifdef EQUIV_CHECKER_STOP_ON_FAIL_EN
    check("xor_done_cyc", r_done, 2);
    check("xor_count", r_cnt, 1);
    check("xor_busy_cycles", r_busy_cnt, 1);
`else
    check("xor_done_cyc", r_done, 5);
    check("xor_count", r_cnt, 4);
    check("xor_busy_cycles", r_busy_cnt, 4);
    check("xor_stim4", r_stim[4], 3);
`endif
    check("xor_ffs", r_ffs, 0);
    check("xor_ffv", r_ffv, 1);
    check("xor_pass", r_pass, 0);
    check("xor_overlap", r_overlap, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/equiv_checker.md
# equiv_checker

Synthesizable exhaustive equivalence checker that sits directly upstream of, and consumes the outputs of, a test design and its ground-truth design. It enumerates every input vector, drives both designs with the same stimulus each cycle, and compares their outputs after a fixed pipeline latency. It reports pass/fail, the mismatch count, and the first failing vector. It provides the in-fabric counterpart of the simulation testbench for pipelined test/ground-truth pairs.

## Interface
- `IN_WIDTH`, default 2: total stimulus width, i.e. all DUT data inputs concatenated; 1..16.
- `OUT_WIDTH`, default 1: total DUT output width.
- `PIPELINE_DEPTH`, default 2: cycles from stimulus to the corresponding DUT output; 0..15.
- `clk  in  1`: single clock, rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `start  in  1`: request a check run.
- `stim_out  out  IN_WIDTH`: registered stimulus driven to both DUTs.
- `test_out  in  OUT_WIDTH`: test-design output.
- `truth_out  in  OUT_WIDTH`: ground-truth output.
- `busy  out  1`: run in progress (RUN or DRAIN).
- `done  out  1`: run complete; results valid.
- `pass  out  1`: high with `done` when zero mismatches occurred.
- `mismatch_count  out  IN_WIDTH+1`: number of mismatching vectors.
- `first_fail_valid  out  1`: at least one mismatch has been captured.
- `first_fail_stim  out  IN_WIDTH`: stimulus of the first mismatch.

## Operation
- FSM states are IDLE, RUN, DRAIN and DONE. Reset forces IDLE.
- All outputs are 0 after reset, including `stim_out`, counters and flags.
- **IDLE:** `start` moves the FSM to RUN. On entry, `stim_out`=0, `mismatch_count`=0 and `first_fail_valid`=0.
- **RUN:** `stim_out` increments by 1 every cycle. After the cycle presenting 2^IN_WIDTH−1, the FSM goes to DRAIN. If PIPELINE_DEPTH=0 it goes straight to DONE.
- **DRAIN:** lasts exactly PIPELINE_DEPTH cycles, then the FSM goes to DONE. `stim_out` holds its last value.
- **DONE:** `done`=1 and `pass`=(mismatch_count==0). `start` restarts the run (IDLE entry actions, then RUN).
- `start` is ignored while `busy`.
- **Comparison:** a delay line carries (valid, stim) PIPELINE_DEPTH cycles behind `stim_out`. When the delayed valid is high, `test_out != truth_out` increments `mismatch_count`. If `first_fail_valid`=0, the delayed stim is latched into `first_fail_stim` and `first_fail_valid` is set.
- Comparison is a bitwise inequality over the full `OUT_WIDTH`.
- `mismatch_count` is sized IN_WIDTH+1 so it can hold 2^IN_WIDTH and never saturates.
- **Reset mid-run:** results are discarded, the delay line is cleared and the FSM returns to IDLE. No stale valid may produce a count after the next start.

## Timing
- Let cycle 0 be the cycle in which `start` is sampled.
- `stim_out`=v during cycle 1+v.
- The output for v is compared at the end of cycle 1+v+PIPELINE_DEPTH.
- `busy` is high from cycle 1 through cycle 2^IN_WIDTH+PIPELINE_DEPTH.
- `done` rises in cycle 2^IN_WIDTH+PIPELINE_DEPTH+1 and holds until restart or reset.
- `done` and `busy` are never high together.
- All outputs are registered.

## Configuration
- With `EQUIV_CHECKER_STOP_ON_FAIL_EN` defined:
  - The first mismatch moves the FSM directly to DONE on the next cycle.
  - In-flight compares are discarded, so `mismatch_count`=1.
  - `stim_out` freezes at its current value.
- Without the macro, the full 2^IN_WIDTH space is always checked and every mismatch is counted.

## Structure
- `equiv_checker_pkg` holds the state enum `equiv_state_t` and the `MAX_PIPELINE_DEPTH`=15 constant.
- Sub-module `equiv_delay_line`: a parameterized shift register of {valid, stim}, depth PIPELINE_DEPTH, with a pass-through at depth 0. It is synchronously cleared by `rst` and when the FSM enters RUN.

## Test plan
- IN_WIDTH=2, PIPELINE_DEPTH=2, both DUTs are 2-stage AND (one a&b, one ~(~a|~b)):
  - `done` rises in cycle 7.
  - `pass`=1 and `mismatch_count`=0.
  - `stim_out` sequence is 0,1,2,3.
- Same setup, but the test DUT is a 2-stage OR:
  - mismatches occur at vectors 1 and 2.
  - `mismatch_count`=2, `first_fail_stim`=1 and `pass`=0.
- PIPELINE_DEPTH=0 with combinational XOR vs XNOR DUTs:
  - `mismatch_count`=4, `first_fail_stim`=0.
  - `done` rises in cycle 5.
- Pulse `start` in cycle 3 during a run: run length and results are unchanged.
  - Then pulse `start` in DONE: a second run produces identical results.
- Assert `rst` in cycle 3 with the mismatching OR DUT, then restart with matching DUTs:
  - `mismatch_count`=0 and `pass`=1.
- With `EQUIV_CHECKER_STOP_ON_FAIL_EN` and the OR DUT:
  - `done` rises one cycle after vector 1 is compared.
  - `mismatch_count`=1 and `first_fail_stim`=1.
